alu_seq_ctrl: RTL and testbench



---
 rtl/alu_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Command sequencer around an 8-bit ALU: single-cycle logic/arith ops plus an
// 8x8 unsigned shift-add multiply that reuses the ALU add path.
module alu_seq_ctrl #(
   parameter int unsigned MUL_ITERS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic [3:0]  rsp_flags,
   output logic        rsp_err,
   output logic        busy
);

   typedef enum logic [1:0] {StIdle, StExec, StMul, StResp} state_e;

   localparam logic [2:0] OpMul    = 3'b101;
   localparam logic [2:0] LastIter = 3'(MUL_ITERS - 1);

   state_e      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [7:0]  a_q, a_d, b_q, b_d;
   logic [7:0]  p_hi_q, p_hi_d, p_lo_q, p_lo_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [15:0] rsp_data_q, rsp_data_d;
   logic [3:0]  rsp_flags_q, rsp_flags_d;
   logic        rsp_err_q, rsp_err_d;

   // alu8 datapath
   logic [2:0]  alu_ctl;
   logic [7:0]  alu_a, alu_b, alu_bm, alu_sum, alu_res;
   logic        alu_cout, alu_z, alu_n, alu_v;
   logic [15:0] mul_next;
   logic        arith_op;

   always_comb begin
      alu_bm = alu_ctl[2] ? ~alu_b : alu_b;
      {alu_cout, alu_sum} = {1'b0, alu_a} + {1'b0, alu_bm} + {8'h00, alu_ctl[2]};
      case (alu_ctl[1:0])
         2'b00:   alu_res = alu_a & alu_b;
         2'b01:   alu_res = alu_a | alu_b;
         2'b10:   alu_res = alu_sum;
         default: alu_res = {7'b0, alu_sum[7]};
      endcase
      alu_z = (alu_res == 8'h00);
      alu_n = alu_res[7];
      alu_v = (alu_a[7] == alu_bm[7]) && (alu_sum[7] != alu_a[7]);
   end

   // MUL owns the ALU as an adder; otherwise it is driven from the latched command
   always_comb begin
      alu_ctl = 3'b010;
      alu_a   = p_hi_q;
      alu_b   = p_lo_q[0] ? a_q : 8'h00;
      if (state_q != StMul) begin
         alu_a = a_q;
         alu_b = b_q;
         case (op_q)
            3'b000:  alu_ctl = 3'b000;
            3'b001:  alu_ctl = 3'b001;
            3'b010:  alu_ctl = 3'b010;
            3'b011:  alu_ctl = 3'b110;
            3'b100:  alu_ctl = 3'b111;
            default: alu_ctl = 3'b000;
         endcase
      end
   end

   assign mul_next = {alu_cout, alu_sum, p_lo_q[7:1]};
   assign arith_op = (op_q == 3'b010) || (op_q == 3'b011);

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      p_hi_d      = p_hi_q;
      p_lo_d      = p_lo_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_flags_d = rsp_flags_q;
      rsp_err_d   = rsp_err_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               op_d = cmd_op;
               a_d  = cmd_a;
               b_d  = cmd_b;
               if (cmd_op == OpMul) begin
                  state_d = StMul;
                  cnt_d   = 3'd0;
                  p_hi_d  = 8'h00;
                  p_lo_d  = cmd_b;
               end else begin
                  state_d = StExec;
               end
            end
         end
         StExec: begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            if (op_q > OpMul) begin
               rsp_data_d  = 16'h0000;
               rsp_flags_d = 4'b0000;
               rsp_err_d   = 1'b1;
            end else begin
               rsp_data_d  = {8'h00, alu_res};
               rsp_flags_d = {alu_z, alu_n, arith_op & alu_cout, arith_op & alu_v};
               rsp_err_d   = 1'b0;
            end
         end
         StMul: begin
            {p_hi_d, p_lo_d} = mul_next;
            cnt_d            = cnt_q + 3'd1;
            if (cnt_q == LastIter) begin
               state_d     = StResp;
               rsp_valid_d = 1'b1;
               rsp_data_d  = mul_next;
               rsp_flags_d = {(mul_next == 16'h0000), 1'b0, (mul_next[15:8] != 8'h00), 1'b0};
               rsp_err_d   = 1'b0;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d     = StIdle;
               rsp_valid_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         op_q        <= 3'b000;
         a_q         <= 8'h00;
         b_q         <= 8'h00;
         p_hi_q      <= 8'h00;
         p_lo_q      <= 8'h00;
         cnt_q       <= 3'd0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 16'h0000;
         rsp_flags_q <= 4'b0000;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         p_hi_q      <= p_hi_d;
         p_lo_q      <= p_lo_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_flags_q <= rsp_flags_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign cmd_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_flags = rsp_flags_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed literal cases plus randomized traffic checked
// every cycle against a transaction-level reference model.
module tb_alu_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [7:0]  cmd_a, cmd_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic [3:0]  rsp_flags;
   logic        rsp_err;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   alu_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_flags (rsp_flags),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference result as {err, Z, N, C, V, data[15:0]} from plain arithmetic
   function automatic logic [20:0] ref_rsp(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
      int ua = int'(a);
      int ub = int'(b);
      int sa = int'($signed(a));
      int sb = int'($signed(b));
      logic [15:0] d = 16'h0000;
      logic z, n, c = 1'b0, v = 1'b0, err = 1'b0;
      case (op)
         3'd0: d = 16'(a & b);
         3'd1: d = 16'(a | b);
         3'd2: begin
            d = 16'((ua + ub) & 255);
            c = (ua + ub) > 255;
            v = (sa + sb) > 127 || (sa + sb) < -128;
         end
         3'd3: begin
            d = 16'((ua - ub) & 255);
            c = ua >= ub;
            v = (sa - sb) > 127 || (sa - sb) < -128;
         end
         3'd4: d = (((ua - ub) & 255) >= 128) ? 16'd1 : 16'd0;
         3'd5: begin
            d = 16'(ua * ub);
            c = (ua * ub) > 255;
         end
         default: err = 1'b1;
      endcase
      z = (d == 16'h0000) && !err;
      n = (op < 3'd5) && d[7];
      return {err, z, n, c, v, d};
   endfunction

   // Transaction model: accept in idle, respond after fixed latency, hold until taken
   logic        m_pending, m_valid, m_ready;
   int          m_cnt;
   logic [20:0] m_next, m_exp;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pending <= 1'b0;
         m_valid   <= 1'b0;
         m_cnt     <= 0;
         m_next    <= '0;
         m_exp     <= '0;
      end else if (m_valid) begin
         if (rsp_ready) m_valid <= 1'b0;
      end else if (m_pending) begin
         if (m_cnt == 1) begin
            m_pending <= 1'b0;
            m_valid   <= 1'b1;
            m_exp     <= m_next;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end else if (cmd_valid) begin
         m_pending <= 1'b1;
         m_cnt     <= (cmd_op == 3'd5) ? 8 : 1;
         m_next    <= ref_rsp(cmd_op, cmd_a, cmd_b);
      end
   end

   assign m_ready = !m_pending && !m_valid;

   always @(negedge clk) begin
      if (!rst) begin
         chk("cmd_ready", 32'(cmd_ready), 32'(m_ready));
         chk("busy", 32'(busy), 32'(!m_ready));
         chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
         if (m_valid) begin
            chk("rsp_data", 32'(rsp_data), 32'(m_exp[15:0]));
            chk("rsp_flags", 32'(rsp_flags), 32'(m_exp[19:16]));
            chk("rsp_err", 32'(rsp_err), 32'(m_exp[20]));
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int lat);
      int guard = 0;
      while (!cmd_ready && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk("send_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic take();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic lit(input string name, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input int exp_lat, input logic [15:0] exp_d,
                      input logic [3:0] exp_f, input logic exp_e);
      int lat;
      send(op, a, b, lat);
      chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({name, "_data"}, 32'(rsp_data), 32'(exp_d));
      chk({name, "_flags"}, 32'(rsp_flags), 32'(exp_f));
      chk({name, "_err"}, 32'(rsp_err), 32'(exp_e));
      take();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_a     = 8'h00;
      cmd_b     = 8'h00;
      rsp_ready = 1'b0;
      #12;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      lit("add", 3'd2, 8'h7F, 8'h01, 1, 16'h0080, 4'b0101, 1'b0);
      lit("sub", 3'd3, 8'h05, 8'h05, 1, 16'h0000, 4'b1010, 1'b0);
      lit("slt", 3'd4, 8'h80, 8'h01, 1, 16'h0000, 4'b1000, 1'b0);
      lit("mul_ff", 3'd5, 8'hFF, 8'hFF, 8, 16'hFE01, 4'b0010, 1'b0);
      lit("mul_0", 3'd5, 8'h00, 8'h37, 8, 16'h0000, 4'b1000, 1'b0);
      lit("mul_d_b", 3'd5, 8'h0D, 8'h0B, 8, 16'h008F, 4'b0000, 1'b0);

      // Backpressure: response must hold and a stray command must be ignored
      send(3'd2, 8'h10, 8'h20, lat);
      chk("bp_lat", 32'(lat), 32'd1);
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_data", 32'(rsp_data), 32'h0030);
         chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
         if (k == 2) begin
            cmd_valid = 1'b1;
            cmd_op    = 3'd1;
            cmd_a     = 8'h55;
            cmd_b     = 8'h0A;
         end
         @(posedge clk);
         #1;
         cmd_valid = 1'b0;
      end
      take();
      chk("bp_release_ready", 32'(cmd_ready), 32'd1);
      chk("bp_release_valid", 32'(rsp_valid), 32'd0);

      lit("illegal", 3'd6, 8'hAA, 8'h55, 1, 16'h0000, 4'b0000, 1'b1);
      lit("or_after", 3'd1, 8'hF0, 8'h0F, 1, 16'h00FF, 4'b0100, 1'b0);

      // Asynchronous reset in the middle of a multiply
      cmd_valid = 1'b1;
      cmd_op    = 3'd5;
      cmd_a     = 8'h03;
      cmd_b     = 8'h04;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         chk("arst_no_rsp", 32'(rsp_valid), 32'd0);
      end
      lit("mul_3_4", 3'd5, 8'h03, 8'h04, 8, 16'h000C, 4'b0000, 1'b0);

      // Random traffic; the negedge compare process checks every cycle
      repeat (3000) begin
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_op    = 3'($urandom);
         cmd_a     = 8'($urandom);
         cmd_b     = 8'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (12) @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
